// File: rtl/tisc_pkg.sv
// rtl/tisc_pkg.sv - shared register-file constants, typedefs and dump FSM state encoding
package tisc_pkg;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        DONE
    } dump_state_t;
endpackage

// File: rtl/stream_out_reg.sv
// rtl/stream_out_reg.sv - output beat register holding data/addr/last until accepted
// Optional out_sum tag when REGFILE_DUMP_CHECKSUM_EN is defined.
module stream_out_reg #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_last,
`ifdef REGFILE_DUMP_CHECKSUM_EN
    input  logic              in_sum,
    output logic              out_sum,
`endif
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            out_sum   <= 1'b0;
`endif
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_addr  <= in_addr;
            out_last  <= in_last;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            out_sum   <= in_sum;
`endif
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks a wrapping register range and streams each word out
// REGFILE_DUMP_CHECKSUM_EN adds out_sum and a trailing XOR checksum beat.
module regfile_dump_reader #(
    parameter int DATA_W   = tisc_pkg::DATA_W,
    parameter int ADDR_W   = tisc_pkg::ADDR_W,
    parameter int NUM_REGS = tisc_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
`ifdef REGFILE_DUMP_CHECKSUM_EN
    output logic              out_sum,
`endif
    output logic              out_last
);
    import tisc_pkg::*;

    dump_state_t       state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] end_addr;
    logic              load;
    logic              accept;
    logic [DATA_W-1:0] beat_data;
    logic [ADDR_W-1:0] beat_addr;
    logic              beat_last;

    assign rd_addr = ptr;
    assign load    = (state == FETCH);
    assign accept  = (state == SEND) && out_valid && out_ready;

`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    logic              sum_phase;

    // The checksum beat reuses FETCH/SEND; sum_phase selects it over register data.
    assign beat_data = sum_phase ? sum : rd_data;
    assign beat_addr = sum_phase ? '0 : ptr;
    assign beat_last = sum_phase;
`else
    assign beat_data = rd_data;
    assign beat_addr = ptr;
    assign beat_last = (ptr == end_addr);
`endif

    stream_out_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .in_data   (beat_data),
        .in_addr   (beat_addr),
        .in_last   (beat_last),
`ifdef REGFILE_DUMP_CHECKSUM_EN
        .in_sum    (sum_phase),
        .out_sum   (out_sum),
`endif
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            end_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            sum       <= '0;
            sum_phase <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        ptr      <= first_addr;
                        end_addr <= last_addr;
                        busy     <= 1'b1;
                        state    <= FETCH;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        sum       <= '0;
                        sum_phase <= 1'b0;
`endif
                    end
                end
                FETCH: begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    if (!sum_phase) sum <= sum ^ rd_data;
`endif
                    state <= SEND;
                end
                SEND: begin
                    if (accept) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        if (sum_phase) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (ptr == end_addr) begin
                            sum_phase <= 1'b1;
                            state     <= FETCH;
                        end else begin
                            ptr   <= ADDR_W'((int'(ptr) + 1) % NUM_REGS);
                            state <= FETCH;
                        end
`else
                        if (ptr == end_addr) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            ptr   <= ADDR_W'((int'(ptr) + 1) % NUM_REGS);
                            state <= FETCH;
                        end
`endif
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - scoreboard bench for regfile_dump_reader
// Define REGFILE_DUMP_CHECKSUM_EN to exercise the checksum beat.
module tb_regfile_dump_reader;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] first_addr;
    logic [2:0] last_addr;
    logic       busy;
    logic       done;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_addr;
    logic       out_last;
    logic       sum_bit;

    logic [7:0] regs [8];
    assign rd_data = regs[rd_addr];

    always #5 clk = ~clk;

    regfile_dump_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .busy       (busy),
        .done       (done),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
`ifdef REGFILE_DUMP_CHECKSUM_EN
        .out_sum    (sum_bit),
`endif
        .out_last   (out_last)
    );
`ifndef REGFILE_DUMP_CHECKSUM_EN
    assign sum_bit = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] a;
        logic       l;
        logic       s;
    } beat_t;

    beat_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    beats_seen  = 0;
    int    done_cnt    = 0;
    int    stall       = 0;
    logic  bp_en       = 1'b0;
    logic  held        = 1'b0;
    beat_t held_beat;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected beats for a range, computed from the bench's register image.
    task automatic push_dump(input logic [2:0] f, input logic [2:0] l);
        int         n;
        logic [2:0] a;
        logic [7:0] x;
        n = int'(3'(l - f)) + 1;
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            a = 3'(f + 3'(i));
            x = x ^ regs[a];
`ifdef REGFILE_DUMP_CHECKSUM_EN
            exp_q.push_back('{d: regs[a], a: a, l: 1'b0, s: 1'b0});
`else
            exp_q.push_back('{d: regs[a], a: a, l: (i == n - 1), s: 1'b0});
`endif
        end
`ifdef REGFILE_DUMP_CHECKSUM_EN
        exp_q.push_back('{d: x, a: 3'd0, l: 1'b1, s: 1'b1});
`endif
    endtask

    always @(posedge clk) begin
        #1;
        if (bp_en && beats_seen == 1 && stall < 5) begin
            out_ready = 1'b0;
            stall++;
        end else begin
            out_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                done_cnt++;
                check_eq("done_busy_low", 32'(busy), 32'd0);
            end
            if (out_valid && !out_ready) begin
                if (held) begin
                    check_eq("stall_data", 32'(out_data), 32'(held_beat.d));
                    check_eq("stall_addr", 32'(out_addr), 32'(held_beat.a));
                end
                held      = 1'b1;
                held_beat = '{d: out_data, a: out_addr, l: out_last, s: sum_bit};
            end
            if (out_valid && out_ready) begin
                held = 1'b0;
                check_eq("beat_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check_eq("beat_data", 32'(out_data), 32'(e.d));
                    check_eq("beat_addr", 32'(out_addr), 32'(e.a));
                    check_eq("beat_last", 32'(out_last), 32'(e.l));
                    check_eq("beat_sum",  32'(sum_bit),  32'(e.s));
                end
                beats_seen++;
            end
        end
    end

    task automatic do_start(input logic [2:0] f, input logic [2:0] l);
        @(posedge clk);
        #1;
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string tag, output int cyc);
        logic seen;
        seen = 1'b0;
        cyc  = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic run_dump(input string tag, input logic [2:0] f, input logic [2:0] l);
        int cyc;
        int d0;
        d0         = done_cnt;
        beats_seen = 0;
        push_dump(f, l);
        do_start(f, l);
        wait_done(tag, cyc);
        @(negedge clk);
        @(negedge clk);
        check_eq({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check_eq({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        int cyc;
        int d0;
        rst        = 1'b1;
        start      = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        out_ready  = 1'b1;
        for (int i = 0; i < 8; i++) regs[i] = 8'(8'h10 + i);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy",  32'(busy),      32'd0);
        check_eq("rst_done",  32'(done),      32'd0);
        check_eq("rst_data",  32'(out_data),  32'd0);
        check_eq("rst_rdaddr", 32'(rd_addr),  32'd0);
        rst = 1'b0;

`ifdef REGFILE_DUMP_CHECKSUM_EN
        regs[0] = 8'h01;
        regs[1] = 8'h02;
        regs[2] = 8'h04;
        run_dump("csum", 3'd0, 3'd2);
        check_eq("csum_beats", 32'(beats_seen), 32'd4);
        for (int i = 0; i < 8; i++) regs[i] = 8'(8'h10 + i);
`endif

        // Full dump with start-to-done timing.
        beats_seen = 0;
        d0 = done_cnt;
        push_dump(3'd0, 3'd7);
        do_start(3'd0, 3'd7);
        wait_done("full", cyc);
        check_eq("full_latency_ok", 32'(cyc >= 14 && cyc <= 19), 32'd1);
        @(negedge clk);
        check_eq("full_queue_empty", 32'(exp_q.size()), 32'd0);
        check_eq("full_done_once", 32'(done_cnt - d0), 32'd1);

        regs[5] = 8'hA5;
        run_dump("single", 3'd5, 3'd5);

        for (int i = 0; i < 8; i++) regs[i] = 8'($urandom_range(0, 255));
        run_dump("wrap", 3'd6, 3'd1);

        // Backpressure on beat 2 with stray start pulses while busy.
        bp_en      = 1'b1;
        stall      = 0;
        beats_seen = 0;
        d0         = done_cnt;
        push_dump(3'd1, 3'd5);
        do_start(3'd1, 3'd5);
        for (int i = 0; i < 50 && stall < 2; i++) @(posedge clk);
        #1;
        first_addr = 3'd3;
        last_addr  = 3'd3;
        start      = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("bp", cyc);
        bp_en = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("bp_stalled", 32'(stall), 32'd5);
        check_eq("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        check_eq("bp_done_once", 32'(done_cnt - d0), 32'd1);

        // Reset during the third beat's SEND.
        beats_seen = 0;
        d0 = done_cnt;
        push_dump(3'd0, 3'd7);
        do_start(3'd0, 3'd7);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (beats_seen == 2 && out_valid) break;
        end
        check_eq("mid_reached_beat3", 32'(beats_seen == 2 && out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_busy",  32'(busy),      32'd0);
        check_eq("mid_rst_data",  32'(out_data),  32'd0);
        check_eq("mid_rst_addr",  32'(out_addr),  32'd0);
        check_eq("mid_rst_last",  32'(out_last),  32'd0);
        check_eq("mid_rst_rdaddr", 32'(rd_addr),  32'd0);
        exp_q.delete();
        held = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("mid_no_done", 32'(done_cnt - d0), 32'd0);
        run_dump("after_rst", 3'd2, 3'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
